// File: rtl/ustcpv_ifetch_if.sv
// ustcpv_ifetch_if -- instruction-fetch memory bus (valid/ack, single beat).
//   MREQ   : read request, held high until the ack is sampled
//   MADDR  : word-aligned request address, stable while MREQ=1
//   MACK   : ack, MRDATA is valid in the same cycle
//   MRDATA : read data
// master = fetch unit, slave = memory.
interface ustcpv_ifetch_if;
  logic        MREQ;
  logic [31:0] MADDR;
  logic        MACK;
  logic [31:0] MRDATA;

  modport master (output MREQ, MADDR, input MACK, MRDATA);
  modport slave  (input MREQ, MADDR, output MACK, MRDATA);
endinterface

// File: rtl/ustcpv_ifetch.sv
// ustcpv_ifetch -- instruction fetch unit in front of the ustcpv core.
// Serves the core's combinational IADDR from a two-entry tagged buffer.
// On a miss the word is fetched over the mem bus and the core is held on HLT.
// Build option: IFETCH_PREFETCH_EN adds a next-word prefetcher. It fires from
// IDLE when IADDR hits and IADDR+4 is in neither entry.
// Ports:
//   CLK, RES      clock (rising edge), async active-low reset
//   IADDR/IDATA   core fetch address / instruction (valid when HLT=0)
//   HLTI/HLT      external halt in / core halt out (HLTI | ~hit)
//   IFLUSH        invalidate both entries
//   mem           fetch bus master (MREQ/MADDR registered)
module ustcpv_ifetch #(
  parameter logic [31:0] NOP_WORD = 32'h00000013
) (
  input  logic                   CLK,
  input  logic                   RES,
  input  logic [31:0]            IADDR,
  output logic [31:0]            IDATA,
  input  logic                   HLTI,
  output logic                   HLT,
  input  logic                   IFLUSH,
  ustcpv_ifetch_if.master        mem
);

  typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;
  typedef struct packed {
    logic        vld;
    logic [29:0] tag;
    logic [31:0] data;
  } ent_t;

  state_t      state;
  ent_t [1:0]  ent;
  logic        vict;      // victim entry for the next fill
  logic        pflush;    // flush seen while BUSY: drop the completing fill
  logic [29:0] req_tag;   // word address of the outstanding request

  logic [29:0] itag;
  logic [1:0]  hitv;
  logic        hit;
  logic        start;
  logic [29:0] start_tag;
  logic        done;
  logic        drop;
  logic        unused_lsb;

  assign itag       = IADDR[31:2];
  assign unused_lsb = ^IADDR[1:0];

  always_comb begin
    hitv = '0;
    for (int k = 0; k < 2; k++)
      hitv[k] = ent[k].vld && (ent[k].tag == itag);
  end

  assign hit   = |hitv;
  assign IDATA = hitv[0] ? ent[0].data :
                 hitv[1] ? ent[1].data : NOP_WORD;
  assign HLT   = HLTI | ~hit;

`ifdef IFETCH_PREFETCH_EN
  logic [29:0] ptag;
  logic        pf_hit;
  // 30-bit word increment: 0xFFFFFFFC wraps to 0x00000000
  assign ptag      = itag + 30'd1;
  assign pf_hit    = (ent[0].vld && ent[0].tag == ptag) ||
                     (ent[1].vld && ent[1].tag == ptag);
  assign start     = !IFLUSH && (!hit || !pf_hit);
  assign start_tag = hit ? ptag : itag;
`else
  assign start     = !IFLUSH && !hit;
  assign start_tag = itag;
`endif

  // The demand/prefetch distinction only decides where a request points.
  // Completion is handled identically, so the kind is not stored.
  assign done      = (state == BUSY) && mem.MACK;
  assign drop      = IFLUSH || pflush;
  assign mem.MREQ  = (state == BUSY);
  assign mem.MADDR = {req_tag, 2'b00};

  always_ff @(posedge CLK or negedge RES) begin
    if (!RES) begin
      state   <= IDLE;
      req_tag <= '0;
      ent     <= '0;
      vict    <= 1'b0;
      pflush  <= 1'b0;
    end else begin
      case (state)
        IDLE: if (start) begin
          state   <= BUSY;
          req_tag <= start_tag;
        end
        BUSY: if (mem.MACK) begin
          // returning to IDLE forces at least one MREQ-low cycle
          state  <= IDLE;
          pflush <= 1'b0;
        end else if (IFLUSH) begin
          pflush <= 1'b1;
        end
      endcase

      if (IFLUSH) begin
        ent[0].vld <= 1'b0;
        ent[1].vld <= 1'b0;
      end else if (done && !pflush) begin
        ent[vict] <= {1'b1, req_tag, mem.MRDATA};
      end

      // A fill toggle beats the hit update; a dropped fill leaves V alone.
      if (done) begin
        if (!drop) vict <= ~vict;
      end else if (hit) begin
        vict <= hitv[0];
      end
    end
  end

endmodule

// File: tb/tb_ustcpv_ifetch.sv
module tb_ustcpv_ifetch;
  localparam logic [31:0] NOP = 32'h00000013;

  logic        CLK = 1'b0;
  logic        RES = 1'b0;
  logic [31:0] IADDR = '0;
  logic [31:0] IDATA;
  logic        HLTI = 1'b0;
  logic        HLT;
  logic        IFLUSH = 1'b0;

  ustcpv_ifetch_if bus();

  ustcpv_ifetch #(.NOP_WORD(NOP)) dut (
    .CLK(CLK), .RES(RES), .IADDR(IADDR), .IDATA(IDATA),
    .HLTI(HLTI), .HLT(HLT), .IFLUSH(IFLUSH), .mem(bus)
  );

  always #5 CLK = ~CLK;

  int n_vec = 0;
  int n_err = 0;

  logic [31:0] exp_req[$];    // expected MADDR per new request
  logic [31:0] exp_instr[$];  // expected IDATA per core fetch

  // memory responder controls: 0=ack after ack_dly wait cycles, 1=MACK forced, 2=MACK toggles
  int   mack_mode  = 2;
  logic mack_force = 1'b0;
  int   ack_dly    = 0;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == 32'h0) return 32'h00500093;
    return {a[19:0], 12'h013};
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // memory side
  initial begin
    int wcnt;
    wcnt = 0;
    bus.MACK = 1'b0;
    bus.MRDATA = '0;
    forever begin
      @(posedge CLK); #1;
      if (mack_mode == 1) begin
        bus.MACK   = mack_force;
        bus.MRDATA = bus.MREQ ? mem_word(bus.MADDR) : 32'hDEADBEEF;
      end else if (mack_mode == 2) begin
        bus.MACK   = ~bus.MACK;
        bus.MRDATA = 32'hDEADBEEF;
      end else if (bus.MREQ && RES) begin
        if (wcnt >= ack_dly) begin
          bus.MACK = 1'b1; bus.MRDATA = mem_word(bus.MADDR); wcnt = 0;
        end else begin
          bus.MACK = 1'b0; bus.MRDATA = 32'h0BAD0BAD; wcnt++;
        end
      end else begin
        bus.MACK = 1'b0; wcnt = 0;
      end
    end
  end

  // monitor: pops the scoreboard whenever the DUT presents a request or an instruction
  logic        in_txn = 1'b0;
  logic        ack_prev = 1'b0;
  logic [31:0] cur_addr = '0;
  always @(negedge CLK) begin
    if (!RES) begin
      in_txn = 1'b0; ack_prev = 1'b0;
    end else begin
      if (ack_prev) chk("mreq_low_after_ack", {31'b0, bus.MREQ}, 32'd0);
      ack_prev = 1'b0;
      if (bus.MREQ) begin
        if (!in_txn) begin
          if (exp_req.size() == 0) begin
            n_vec++; n_err++;
            $display("FAIL unexpected_req: got MADDR %h expected no request", bus.MADDR);
          end else chk("maddr", bus.MADDR, exp_req.pop_front());
          in_txn = 1'b1; cur_addr = bus.MADDR;
        end else chk("maddr_hold", bus.MADDR, cur_addr);
        if (bus.MACK) begin in_txn = 1'b0; ack_prev = 1'b1; end
      end else in_txn = 1'b0;
      if (!HLT && exp_instr.size() > 0) chk("idata", IDATA, exp_instr.pop_front());
    end
  end

  // Present a, optionally out of reset; count stall cycles and MREQ cycles until HLT=0.
  task automatic fetch(input bit do_rst, input logic [31:0] a, input logic [31:0] d,
                       input int stall, input int mcyc);
    int hc, mc;
    bit ok;
    hc = 0; mc = 0; ok = 0;
    @(posedge CLK); #1;
    if (do_rst) begin
      RES = 1'b0;
      repeat (2) @(posedge CLK);
      #1;
    end
    IADDR = a;
    RES = 1'b1;
    exp_instr.push_back(d);
    for (int i = 0; i < 60 && !ok; i++) begin
      @(negedge CLK);
      if (HLT) begin hc++; if (bus.MREQ) mc++; end
      else ok = 1;
    end
    if (!ok) begin
      n_vec++; n_err++;
      $display("FAIL timeout@%h: got HLT stuck high expected release", a);
      exp_instr.delete();
    end else begin
      chk($sformatf("stall@%h", a), hc, stall);
      chk($sformatf("mreq_cycles@%h", a), mc, mcyc);
    end
  endtask

  // Pulse IFLUSH in the first MREQ cycle, or in the first ack cycle.
  task automatic flush_on(input bit at_ack);
    bit fired;
    fired = 0;
    for (int i = 0; i < 80 && !fired; i++) begin
      @(posedge CLK); #2;
      if (RES && bus.MREQ && (!at_ack || bus.MACK)) begin
        IFLUSH = 1'b1; fired = 1;
        @(posedge CLK); #1;
        IFLUSH = 1'b0;
      end
    end
    chk("flush_fired", {31'b0, fired}, 32'd1);
  endtask

  initial begin
    // reset held, MACK toggling
    for (int i = 0; i < 4; i++) begin
      @(negedge CLK);
      chk("rst_mreq", {31'b0, bus.MREQ}, 32'd0);
      chk("rst_hlt", {31'b0, HLT}, 32'd1);
      chk("rst_idata", IDATA, NOP);
    end
    // release with MACK tied high
    mack_mode = 1; mack_force = 1'b1;
    exp_req.push_back(32'h0);
    fetch(1, 32'h0, 32'h00500093, 2, 1);
    mack_mode = 0; ack_dly = 0;
`ifdef IFETCH_PREFETCH_EN
    exp_req.push_back(32'h4);
`endif
    repeat (8) @(negedge CLK);

    // ack delay 3
    ack_dly = 3;
    exp_req.push_back(32'h100);
    fetch(1, 32'h100, 32'h00100013, 5, 4);
`ifdef IFETCH_PREFETCH_EN
    exp_req.push_back(32'h104);
`endif
    repeat (10) @(negedge CLK);

    // stray MACK while MREQ=0
    mack_mode = 1; mack_force = 1'b1;
    repeat (2) @(negedge CLK);
    mack_mode = 0;
    @(negedge CLK);
    chk("stray_idata", IDATA, 32'h00100013);
    chk("stray_hlt", {31'b0, HLT}, 32'd0);
    chk("stray_mreq", {31'b0, bus.MREQ}, 32'd0);

    // external halt on a hit
    @(posedge CLK); #2;
    HLTI = 1'b1;
    #1 chk("hlti", {31'b0, HLT}, 32'd1);
    HLTI = 1'b0;

`ifdef IFETCH_PREFETCH_EN
    ack_dly = 3;
    fetch(0, 32'h104, 32'h00104013, 0, 0);
    exp_req.push_back(32'h108);
    // jump while the 0x108 prefetch is outstanding
    exp_req.push_back(32'h200);
    fetch(0, 32'h200, 32'h00200013, 9, 8);
    exp_req.push_back(32'h204);
    fetch(0, 32'h108, 32'h00108013, 0, 0);
    exp_req.push_back(32'h10C);
`else
    ack_dly = 0;
    exp_req.push_back(32'h104);
    fetch(0, 32'h104, 32'h00104013, 2, 1);
    ack_dly = 3;
    exp_req.push_back(32'h200);
    fetch(0, 32'h200, 32'h00200013, 5, 4);
    exp_req.push_back(32'h108);
    fetch(0, 32'h108, 32'h00108013, 5, 4);
    // two-word loop hits from both entries
    fetch(0, 32'h200, 32'h00200013, 0, 0);
    fetch(0, 32'h108, 32'h00108013, 0, 0);
`endif
    repeat (12) @(negedge CLK);

    // IFLUSH coincident with MACK: fill dropped, same address re-requested
    ack_dly = 2;
    exp_req.push_back(32'h300);
    exp_req.push_back(32'h300);
    fork
      fetch(1, 32'h300, 32'h00300013, 8, 6);
      flush_on(1);
    join
`ifdef IFETCH_PREFETCH_EN
    exp_req.push_back(32'h304);
`endif
    repeat (8) @(negedge CLK);

    // IFLUSH early in a transaction: completion still dropped
    ack_dly = 3;
    exp_req.push_back(32'h400);
    exp_req.push_back(32'h400);
    fork
      fetch(1, 32'h400, 32'h00400013, 10, 8);
      flush_on(0);
    join
`ifdef IFETCH_PREFETCH_EN
    exp_req.push_back(32'h404);
`endif
    repeat (10) @(negedge CLK);

    // top of address space, then reset mid-transaction
    ack_dly = 0;
    exp_req.push_back(32'hFFFFFFFC);
    fetch(1, 32'hFFFFFFFC, 32'hFFFFC013, 2, 1);
    ack_dly = 20;
`ifdef IFETCH_PREFETCH_EN
    exp_req.push_back(32'h0);
`else
    exp_req.push_back(32'h500);
    @(posedge CLK); #1;
    IADDR = 32'h500;
`endif
    @(negedge CLK);
    @(negedge CLK);
    chk("pre_rst_mreq", {31'b0, bus.MREQ}, 32'd1);
    #1 RES = 1'b0;
    #1;
    chk("async_rst_mreq", {31'b0, bus.MREQ}, 32'd0);
    chk("async_rst_hlt", {31'b0, HLT}, 32'd1);
    chk("async_rst_idata", IDATA, NOP);

    repeat (3) @(negedge CLK);
    chk("req_queue_drained", exp_req.size(), 32'd0);
    chk("instr_queue_drained", exp_instr.size(), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    n_err++;
    $display("FAIL global_timeout: got no completion expected finish");
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
